cursor_step: RTL and testbench
==============================

CURSOR_STEP -- requirements
Module: cursor_step

Interface
REQ-001 SHALL have parameter POS_W, default 8, meaning coordinate width in bits.
REQ-002 SHALL have parameter X_MAX, default 159, meaning largest legal x coordinate.
REQ-003 SHALL have parameter Y_MAX, default 119, meaning largest legal y coordinate.
REQ-004 SHALL have parameter X_START / Y_START, default 80 / 60, meaning post-reset position.
REQ-005 SHALL have parameter HOLD_CYCLES, default 25_000_000, meaning cycles before auto-repeat begins.
REQ-006 SHALL have parameter REPEAT_CYCLES, default 5_000_000, meaning cycles between auto-repeat steps.
REQ-007 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port dir_x  input  2  x command from the IR decoder: 0 = left (decrement), 1 = right (increment), 2 = none, 3 = none.
REQ-010 SHALL have port dir_y  input  2  y command: 0 = up (decrement), 1 = down (increment), 2 and 3 = none.
REQ-011 SHALL have port pos_x  output  POS_W  current x coordinate.
REQ-012 SHALL have port pos_y  output  POS_W  current y coordinate.
REQ-013 SHALL have port moved  output  1  one-cycle pulse when either coordinate changed.

Function
REQ-014 SHALL pass dir_x and dir_y through a 2-flop synchroniser, because they are asynchronous to clk.
REQ-015 SHALL implement the FSM IDLE -> STEP -> HOLD -> REPEAT.
REQ-016 IDLE: when the synchronised command is not none on either axis, the FSM SHALL go to STEP.
REQ-017 STEP: the block SHALL apply one step on every active axis, latch the command, load the counter with HOLD_CYCLES-1, and go to HOLD.
REQ-018 HOLD: the counter SHALL decrement every cycle; when it reaches 0 and the command is unchanged, the FSM SHALL go to STEP_R.
REQ-019 STEP_R (a repeat step) SHALL behave as STEP except that it loads REPEAT_CYCLES-1 and goes to REPEAT.
REQ-020 REPEAT SHALL behave as HOLD, with expiry leading to STEP_R.
REQ-021 In HOLD or REPEAT, a synchronised command that differs from the latched one and is not none on both axes SHALL cause STEP in the next cycle.
REQ-022 In any state, a command of none on both axes SHALL return the FSM to IDLE in the next cycle, with no step.
REQ-023 A diagonal command (both axes active) SHALL step both coordinates in the same cycle.
REQ-024 Latency: the coordinate register SHALL update on the 4th rising edge after dir changes, i.e. 2 sync edges, 1 FSM edge, 1 step edge.
REQ-025 moved SHALL assert in the same cycle in which pos_x or pos_y shows its new value.
REQ-026 Arithmetic SHALL use POS_W+1 bits internally, so that 0-1 and X_MAX+1 are detected without truncation.
REQ-027 By default, a step beyond 0 or beyond X_MAX/Y_MAX SHALL saturate, leaving the coordinate unchanged.
REQ-028 A saturated step SHALL NOT assert moved unless the other axis changed.

Reset
REQ-029 Reset assertion SHALL immediately force pos_x=X_START, pos_y=Y_START, moved=0, FSM=IDLE, counter=0, and synchronisers to none (2).
REQ-030 Reset asserted mid-HOLD or mid-REPEAT SHALL discard the pending repeat; after release, the block SHALL require a fresh IDLE->STEP transition.

Configuration
REQ-031 The macro CURSOR_WRAP_EN, when defined, SHALL make the coordinates wrap: 0-1 gives MAX, MAX+1 gives 0, and moved asserts.
REQ-032 Without CURSOR_WRAP_EN, the block SHALL saturate per REQ-027/REQ-028.

Structure
REQ-033 Package cursor_pkg SHALL hold typedef enum dir_t {DIR_NEG=0, DIR_POS=1, DIR_NONE=2}, typedef enum state_t {IDLE, STEP, HOLD, STEP_R, REPEAT}, and the DIR_NONE decode helper.
REQ-034 Sub-module cursor_axis, instantiated twice, SHALL compute the next coordinate and a changed flag from (coordinate, dir_t, MAX), including saturate/wrap.
REQ-035 The counter width SHALL be $clog2 of the larger of HOLD_CYCLES and REPEAT_CYCLES, plus 1.

Verification
(Bench parameters: POS_W=4, X_MAX=Y_MAX=9, START=5, HOLD_CYCLES=20, REPEAT_CYCLES=5.)
REQ-036 Hold dir_x=1 for 3 cycles, then 2: pos_x 5->6 at edge 4, one moved pulse, no further step.
REQ-037 Hold dir_x=1 for 40 cycles: pos_x reaches 6, then 7 at +20 cycles and 8 at +25; it then saturates at 9 with moved=0 on later repeats (wraps to 0 with CURSOR_WRAP_EN).
REQ-038 dir_y=0 held from pos_y=0 (start overridden): pos_y stays 0 and moved never asserts; with CURSOR_WRAP_EN, pos_y becomes 9.
REQ-039 dir_x=0 and dir_y=1 together: pos_x=4 and pos_y=6 on the same edge, with a single moved pulse.
REQ-040 Change dir_x 1->0 at cycle 10 of HOLD: an immediate left step with no right repeat, and the HOLD restarts at 20.
REQ-041 Reset pulse during REPEAT at pos_x=8: outputs return to 5/5/0 asynchronously, and no step occurs until dir returns to none and is asserted again.

Source files
------------

// File: rtl/cursor_pkg.sv
// Shared direction/state types and command decode helpers for the cursor stepper.
package cursor_pkg;

  typedef enum logic [1:0] {
    DIR_NEG  = 2'd0,
    DIR_POS  = 2'd1,
    DIR_NONE = 2'd2
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    HOLD,
    STEP_R,
    REPEAT
  } state_t;

  localparam logic [1:0] DIR_RAW_NONE = 2'd2;

  // Raw codes 2 and 3 both mean "no command on this axis".
  function automatic dir_t decode_dir(input logic [1:0] raw);
    case (raw)
      2'd0:    return DIR_NEG;
      2'd1:    return DIR_POS;
      default: return DIR_NONE;
    endcase
  endfunction

  function automatic logic is_none(input dir_t d);
    return d == DIR_NONE;
  endfunction

endpackage

// File: rtl/cursor_axis.sv
// One cursor axis: next coordinate and change flag for a single step command.
// Saturates at 0 / MAX by default; wraps around when CURSOR_WRAP_EN is defined.
module cursor_axis
  import cursor_pkg::*;
#(
  parameter int POS_W = 8,
  parameter int MAX   = 159
) (
  input  logic [POS_W-1:0] coord,
  input  dir_t             dir,
  output logic [POS_W-1:0] next,
  output logic             changed
);

  localparam logic [POS_W:0] MAX_W = (POS_W+1)'(MAX);
  localparam logic [POS_W:0] ONE_W = (POS_W+1)'(1);

  // One extra bit so that 0-1 and MAX+1 are visible before truncation.
  function automatic logic [POS_W-1:0] limit_step(input logic [POS_W:0] wide, input dir_t d);
    logic [POS_W:0]   inc;
    logic [POS_W:0]   dec;
    logic [POS_W-1:0] res;
    inc = wide + ONE_W;
    dec = wide - ONE_W;
    res = wide[POS_W-1:0];
    if (d == DIR_POS) begin
      if (inc <= MAX_W) begin
        res = inc[POS_W-1:0];
      end else begin
`ifdef CURSOR_WRAP_EN
        res = '0;
`else
        res = wide[POS_W-1:0];
`endif
      end
    end else if (d == DIR_NEG) begin
      if (!dec[POS_W]) begin
        res = dec[POS_W-1:0];
      end else begin
`ifdef CURSOR_WRAP_EN
        res = MAX_W[POS_W-1:0];
`else
        res = wide[POS_W-1:0];
`endif
      end
    end
    return res;
  endfunction

  always_comb begin
    next    = limit_step({1'b0, coord}, dir);
    changed = (next != coord);
  end

endmodule

// File: rtl/cursor_step.sv
// Cursor position stepper: synchronises IR direction commands, steps once per
// press and auto-repeats while held. Define CURSOR_WRAP_EN to wrap at the edges.
module cursor_step
  import cursor_pkg::*;
#(
  parameter int POS_W         = 8,
  parameter int X_MAX         = 159,
  parameter int Y_MAX         = 119,
  parameter int X_START       = 80,
  parameter int Y_START       = 60,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       dir_x,
  input  logic [1:0]       dir_y,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             moved
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [POS_W-1:0] X_INIT      = POS_W'(X_START);
  localparam logic [POS_W-1:0] Y_INIT      = POS_W'(Y_START);

  logic [1:0] sync_x_p0;
  logic [1:0] sync_x_p1;
  logic [1:0] sync_y_p0;
  logic [1:0] sync_y_p1;
  logic       vld_p0;
  logic       vld_p1;

  // Stage p0/p1: two-flop synchroniser; vld marks data sampled since reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_x_p0 <= DIR_RAW_NONE;
      sync_x_p1 <= DIR_RAW_NONE;
      sync_y_p0 <= DIR_RAW_NONE;
      sync_y_p1 <= DIR_RAW_NONE;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      sync_x_p0 <= dir_x;
      sync_x_p1 <= sync_x_p0;
      sync_y_p0 <= dir_y;
      sync_y_p1 <= sync_y_p0;
      vld_p0    <= 1'b1;
      vld_p1    <= vld_p0;
    end
  end

  dir_t cmd_x;
  dir_t cmd_y;
  logic cmd_none;

  assign cmd_x    = decode_dir(sync_x_p1);
  assign cmd_y    = decode_dir(sync_y_p1);
  assign cmd_none = is_none(cmd_x) && is_none(cmd_y);

  logic [POS_W-1:0] next_x;
  logic [POS_W-1:0] next_y;
  logic             chg_x;
  logic             chg_y;

  cursor_axis #(
    .POS_W (POS_W),
    .MAX   (X_MAX)
  ) u_axis_x (
    .coord   (pos_x),
    .dir     (cmd_x),
    .next    (next_x),
    .changed (chg_x)
  );

  cursor_axis #(
    .POS_W (POS_W),
    .MAX   (Y_MAX)
  ) u_axis_y (
    .coord   (pos_y),
    .dir     (cmd_y),
    .next    (next_y),
    .changed (chg_y)
  );

  state_t           state;
  logic [CNT_W-1:0] cnt;
  dir_t             lat_x;
  dir_t             lat_y;
  logic             armed;
  logic             cmd_changed;
  logic             cnt_done;

  assign cmd_changed = (cmd_x != lat_x) || (cmd_y != lat_y);
  assign cnt_done    = (cnt <= CNT_ONE);

  // Stage p2: command FSM and position registers.
  // armed needs a genuinely sampled "none" after reset, so a key still held
  // through reset cannot start a new press on its own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      lat_x <= DIR_NONE;
      lat_y <= DIR_NONE;
      armed <= 1'b0;
      pos_x <= X_INIT;
      pos_y <= Y_INIT;
      moved <= 1'b0;
    end else begin
      moved <= 1'b0;
      if (vld_p1 && cmd_none) begin
        armed <= 1'b1;
      end
      if (cmd_none) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (armed) begin
              state <= STEP;
            end
          end
          STEP, STEP_R: begin
            pos_x <= next_x;
            pos_y <= next_y;
            moved <= chg_x | chg_y;
            lat_x <= cmd_x;
            lat_y <= cmd_y;
            if (state == STEP) begin
              cnt   <= HOLD_LOAD;
              state <= HOLD;
            end else begin
              cnt   <= REPEAT_LOAD;
              state <= REPEAT;
            end
          end
          HOLD, REPEAT: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_ONE;
            end
            if (cmd_changed) begin
              state <= STEP;
            end else if (cnt_done) begin
              state <= STEP_R;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cursor_step.sv
// Self-checking bench for cursor_step: directed press/hold scenarios with literal
// expectations plus randomized commands checked every cycle against a model.
module tb_cursor_step;

  localparam int POS_W   = 4;
  localparam int X_MAX   = 9;
  localparam int Y_MAX   = 9;
  localparam int X_START = 5;
  localparam int Y_START = 5;
  localparam int HOLD    = 20;
  localparam int REPEAT  = 5;

`ifdef CURSOR_WRAP_EN
  localparam int SAT_X = 0;
  localparam int SAT_Y = 9;
  localparam int SAT_MOVED = 1;
`else
  localparam int SAT_X = 9;
  localparam int SAT_Y = 0;
  localparam int SAT_MOVED = 0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       dir_x = 2'd2;
  logic [1:0]       dir_y = 2'd2;
  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;
  logic             moved;

  int checks = 0;
  int failures = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  cursor_step #(
    .POS_W         (POS_W),
    .X_MAX         (X_MAX),
    .Y_MAX         (Y_MAX),
    .X_START       (X_START),
    .Y_START       (Y_START),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REPEAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .dir_x (dir_x),
    .dir_y (dir_y),
    .pos_x (pos_x),
    .pos_y (pos_y),
    .moved (moved)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: commands reach the decision logic two edges late; a press
  // steps one edge after it is seen, then every HOLD, then every REPEAT edges.
  int q_x[$];
  int q_y[$];
  int mx, my, edge_n, due, held_x, held_y;
  bit mmoved, busy, fresh, need_none;

  function automatic int norm(input int v);
    return (v == 0 || v == 1) ? v : 2;
  endfunction

  function automatic int step_axis(input int p, input int d, input int lim);
    int t;
    if (d == 1) t = p + 1;
    else if (d == 0) t = p - 1;
    else return p;
    if (t < 0 || t > lim) begin
`ifdef CURSOR_WRAP_EN
      return (t < 0) ? lim : 0;
`else
      return p;
`endif
    end
    return t;
  endfunction

  task automatic model_reset();
    mx = X_START;
    my = Y_START;
    mmoved = 1'b0;
    busy = 1'b0;
    fresh = 1'b0;
    need_none = 1'b1;
    q_x = {-1, -1};
    q_y = {-1, -1};
  endtask

  task automatic model_edge();
    int cx, cy, nx, ny;
    bit act;
    q_x.push_back(int'(dir_x));
    q_y.push_back(int'(dir_y));
    cx = q_x.pop_front();
    cy = q_y.pop_front();
    edge_n++;
    mmoved = 1'b0;
    act = (cx == 0 || cx == 1 || cy == 0 || cy == 1);
    if (!act) begin
      busy = 1'b0;
      if (cx >= 0) need_none = 1'b0;
    end else if (!busy) begin
      if (!need_none) begin
        busy = 1'b1;
        due = edge_n + 1;
        fresh = 1'b1;
      end
    end else if (edge_n == due) begin
      nx = step_axis(mx, cx, X_MAX);
      ny = step_axis(my, cy, Y_MAX);
      mmoved = (nx != mx) || (ny != my);
      mx = nx;
      my = ny;
      held_x = norm(cx);
      held_y = norm(cy);
      due = edge_n + (fresh ? HOLD : REPEAT);
      fresh = 1'b0;
    end else if (norm(cx) != held_x || norm(cy) != held_y) begin
      due = edge_n + 1;
      fresh = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        check("pos_x", int'(pos_x), mx);
        check("pos_y", int'(pos_y), my);
        check("moved", int'(moved), int'(mmoved));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset(input bit clear_dir);
    #2;
    reset = 1'b1;
    #1;
    check("rst_pos_x", int'(pos_x), X_START);
    check("rst_pos_y", int'(pos_y), Y_START);
    check("rst_moved", int'(moved), 0);
    if (clear_dir) begin
      dir_x = 2'd2;
      dir_y = 2'd2;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_on = 1'b1;
    if (clear_dir) tick(4);
  endtask

  initial begin
    pulse_reset(1'b1);

    // Short press: single step on edge 4.
    dir_x = 2'd1;
    tick(3);
    check("press_before", int'(pos_x), 5);
    dir_x = 2'd2;
    tick(1);
    check("press_x", int'(pos_x), 6);
    check("press_moved", int'(moved), 1);
    tick(1);
    check("press_moved_off", int'(moved), 0);
    tick(10);
    check("press_no_repeat", int'(pos_x), 6);

    // Held right: hold delay then repeats, saturating (or wrapping) at the edge.
    pulse_reset(1'b1);
    dir_x = 2'd1;
    tick(4);
    check("hold_first", int'(pos_x), 6);
    check("model_first", mx, 6);
    tick(20);
    check("hold_second", int'(pos_x), 7);
    tick(5);
    check("repeat_first", int'(pos_x), 8);
    check("model_repeat", mx, 8);
    tick(5);
    check("repeat_edge", int'(pos_x), 9);
    tick(5);
    check("repeat_sat_x", int'(pos_x), SAT_X);
    check("repeat_sat_moved", int'(moved), SAT_MOVED);
    tick(1);
    dir_x = 2'd2;
    tick(6);

    // Held up to y=0 and beyond.
    pulse_reset(1'b1);
    dir_y = 2'd0;
    tick(39);
    check("up_reach0", int'(pos_y), 0);
    tick(5);
    check("up_sat_y", int'(pos_y), SAT_Y);
    check("up_sat_moved", int'(moved), SAT_MOVED);
    tick(6);
    dir_y = 2'd2;
    tick(5);

    // Diagonal press.
    pulse_reset(1'b1);
    dir_x = 2'd0;
    dir_y = 2'd1;
    tick(3);
    dir_x = 2'd2;
    dir_y = 2'd2;
    tick(1);
    check("diag_x", int'(pos_x), 4);
    check("diag_y", int'(pos_y), 6);
    check("diag_moved", int'(moved), 1);
    tick(1);
    check("diag_moved_off", int'(moved), 0);

    // Direction change mid-HOLD restarts the hold period.
    pulse_reset(1'b1);
    dir_x = 2'd1;
    tick(4);
    check("chg_first", int'(pos_x), 6);
    tick(9);
    dir_x = 2'd0;
    tick(3);
    check("chg_before", int'(pos_x), 6);
    tick(1);
    check("chg_left", int'(pos_x), 5);
    check("chg_moved", int'(moved), 1);
    tick(7);
    check("chg_no_right", int'(pos_x), 5);
    tick(12);
    check("chg_hold_wait", int'(pos_x), 5);
    tick(1);
    check("chg_hold_repeat", int'(pos_x), 4);
    dir_x = 2'd2;
    tick(5);

    // Reset during REPEAT with the key still held.
    pulse_reset(1'b1);
    dir_x = 2'd1;
    tick(29);
    check("rr_at8", int'(pos_x), 8);
    tick(2);
    pulse_reset(1'b0);
    tick(12);
    check("rr_held_no_step", int'(pos_x), 5);
    dir_x = 2'd2;
    tick(3);
    dir_x = 2'd1;
    tick(3);
    check("rr_before", int'(pos_x), 5);
    tick(1);
    check("rr_fresh_step", int'(pos_x), 6);
    check("rr_fresh_moved", int'(moved), 1);
    dir_x = 2'd2;
    tick(4);

    // Randomized command sequences with occasional resets.
    for (int seg = 0; seg < 70; seg++) begin
      dir_x = 2'($urandom_range(0, 3));
      dir_y = 2'($urandom_range(0, 3));
      tick($urandom_range(1, 30));
      if ($urandom_range(0, 11) == 0) pulse_reset(1'b0);
    end
    dir_x = 2'd2;
    dir_y = 2'd2;
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
